// File: rtl/wb_rr_master_arbiter.sv
// rtl/wb_rr_master_arbiter.sv - round-robin N:1 Wishbone B3 master arbiter with watchdog
module wb_rr_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
    output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [31:0]               wbs_adr_o,
    output logic [31:0]               wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [31:0]               wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_TOERR = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_gnt, r_last, w_gnt_nxt, w_last_nxt, w_pick;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_any, w_arb, w_own_cyc, w_own_stb, w_resp, w_timeout;
    int            w_own;

    assign w_own     = int'(r_gnt);
    assign w_own_cyc = wbm_cyc_i[r_gnt];
    assign w_own_stb = wbm_stb_i[r_gnt];
    assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_timeout = (TIMEOUT > 0) && w_own_stb && !w_resp
                       && (r_cnt == CW'(TIMEOUT - 1));

    // Scan starts just after the previous owner, so the releasing master is checked last.
    always_comb begin
        int            cand;
        logic [IW-1:0] idx;
        w_any  = 1'b0;
        w_pick = '0;
        cand   = 0;
        idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(r_last) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            idx = IW'(cand);
            if (!w_any && wbm_cyc_i[idx]) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = '0;
        w_arb       = 1'b0;
        case (r_state)
            S_IDLE: w_arb = 1'b1;
            S_OWN: begin
                if (!w_own_cyc) begin
                    w_arb = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_TOERR;
                end else if ((TIMEOUT > 0) && w_own_stb && !w_resp) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_TOERR: begin
                if (w_own_cyc) begin
                    w_state_nxt = S_OWN;
                end else begin
                    w_arb = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_arb) begin
            if (w_any) begin
                w_state_nxt = S_OWN;
                w_gnt_nxt   = w_pick;
                w_last_nxt  = w_pick;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_gnt   <= IW'(NUM_MASTERS - 1);
            r_last  <= IW'(NUM_MASTERS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are also gated by reset so nothing leaks while reset is held mid-transfer.
    always_comb begin
        wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        grant_o   = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (!wb_rst_i && (r_state != S_IDLE)) begin
            grant_o[r_gnt] = 1'b1;
            wbs_adr_o      = wbm_adr_i[w_own*32 +: 32];
            wbs_dat_o      = wbm_dat_i[w_own*32 +: 32];
            wbs_sel_o      = wbm_sel_i[w_own*4 +: 4];
            wbs_we_o       = wbm_we_i[r_gnt];
            wbs_cti_o      = wbm_cti_i[w_own*3 +: 3];
            wbs_bte_o      = wbm_bte_i[w_own*2 +: 2];
            if (r_state == S_OWN) begin
                wbs_cyc_o        = w_own_cyc;
                wbs_stb_o        = w_own_stb;
                wbm_ack_o[r_gnt] = wbs_ack_i;
                wbm_err_o[r_gnt] = wbs_err_i;
                wbm_rty_o[r_gnt] = wbs_rty_i;
            end else begin
                wbm_err_o[r_gnt] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// tb/tb_wb_rr_master_arbiter.sv - directed self-checking bench for wb_rr_master_arbiter
module tb_wb_rr_master_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [32*N-1:0] m_adr, m_dat, m_dat_o;
    logic [4*N-1:0]  m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb, m_ack, m_err, m_rty, grant;
    logic [3*N-1:0]  m_cti;
    logic [2*N-1:0]  m_bte;
    logic [31:0]     s_adr, s_dat_o, s_dat_i;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;

    int n_vec = 0;
    int n_bad = 0;
    int acks [N];

    wb_rr_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT(4)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (m_dat_o),
        .wbm_ack_o (m_ack),
        .wbm_err_o (m_err),
        .wbm_rty_o (m_rty),
        .wbs_adr_o (s_adr),
        .wbs_dat_o (s_dat_o),
        .wbs_sel_o (s_sel),
        .wbs_we_o  (s_we),
        .wbs_cyc_o (s_cyc),
        .wbs_stb_o (s_stb),
        .wbs_cti_o (s_cti),
        .wbs_bte_o (s_bte),
        .wbs_dat_i (s_dat_i),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .wbs_rty_i (s_rty),
        .grant_o   (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_sel   = '1;
        m_cti   = '0;
        m_bte   = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rty   = 1'b0;
        s_dat_i = '0;
        for (int k = 0; k < N; k++) begin
            m_adr[k*32 +: 32] = 32'hA000_0000 + 32'(k) * 32'h100;
            m_dat[k*32 +: 32] = 32'h5500_0000 + 32'(k);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset held while a master requests and the slave acks
        do_reset();
        rst   = 1'b1;
        m_cyc = 3'b001;
        m_stb = 3'b001;
        s_ack = 1'b1;
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cyc", 32'(s_cyc), 32'h0);
        chk("rst_ack", 32'(m_ack), 32'h0);

        // two simultaneous requests, read data, back-to-back handover
        do_reset();
        m_cyc = 3'b011;
        m_stb = 3'b011;
        settle();
        chk("lat_cyc", 32'(s_cyc), 32'h0);
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_cyc", 32'(s_cyc), 32'h1);
        chk("first_adr", s_adr, 32'hA000_0000);
        s_ack   = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        settle();
        chk("rd_ack", 32'(m_ack), 32'h1);
        chk("rd_dat0", m_dat_o[31:0], 32'hDEAD_BEEF);
        chk("rd_dat1", m_dat_o[63:32], 32'hDEAD_BEEF);
        tick();
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        settle();
        chk("rel_cyc", 32'(s_cyc), 32'h0);
        tick();
        chk("hand_grant", 32'(grant), 32'h2);
        chk("hand_cyc", 32'(s_cyc), 32'h1);
        chk("hand_adr", s_adr, 32'hA000_0100);
        m_cyc = '0;
        m_stb = '0;
        tick();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_cyc", 32'(s_cyc), 32'h0);
        chk("idle_adr", s_adr, 32'h0);

        // three masters with continuous single-beat requests
        do_reset();
        for (int k = 0; k < N; k++) acks[k] = 0;
        m_cyc = 3'b111;
        m_stb = 3'b111;
        tick();
        for (int t = 0; t < 30; t++) begin
            int o;
            o = t % 3;
            chk("rr_grant", 32'(grant), 32'(1) << o);
            s_ack = 1'b1;
            settle();
            for (int k = 0; k < N; k++) if (m_ack[k]) acks[k]++;
            chk("rr_ack", 32'(m_ack), 32'(1) << o);
            tick();
            s_ack    = 1'b0;
            m_cyc[o] = 1'b0;
            m_stb[o] = 1'b0;
            tick();
            m_cyc[o] = 1'b1;
            m_stb[o] = 1'b1;
        end
        chk("rr_cnt0", 32'(acks[0]), 32'd10);
        chk("rr_cnt1", 32'(acks[1]), 32'd10);
        chk("rr_cnt2", 32'(acks[2]), 32'd10);

        // 8-beat incrementing burst from master0 while master1 waits
        do_reset();
        m_cyc = 3'b011;
        m_stb = 3'b011;
        m_cti[2:0] = 3'b010;
        tick();
        for (int b = 0; b < 8; b++) begin
            logic [2:0] ec;
            ec = (b == 7) ? 3'b111 : 3'b010;
            m_cti[2:0]  = ec;
            m_adr[31:0] = 32'h0000_1000 + 32'(b) * 32'd4;
            s_ack = 1'b1;
            settle();
            chk("bst_ack", 32'(m_ack), 32'h1);
            chk("bst_cti", 32'(s_cti), 32'(ec));
            chk("bst_adr", s_adr, 32'h0000_1000 + 32'(b) * 32'd4);
            tick();
        end
        s_ack    = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
        chk("bst_hand", 32'(grant), 32'h2);
        chk("bst_adr1", s_adr, 32'hA000_0100);

        // watchdog: slave never responds
        do_reset();
        m_cyc = 3'b001;
        m_stb = 3'b001;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wd_err_pre", 32'(m_err), 32'h0);
            chk("wd_stb", 32'(s_stb), 32'h1);
            tick();
        end
        chk("wd_err", 32'(m_err), 32'h1);
        chk("wd_cyc", 32'(s_cyc), 32'h0);
        chk("wd_stb_lo", 32'(s_stb), 32'h0);
        s_ack = 1'b1;
        settle();
        chk("wd_late", 32'(m_ack), 32'h0);
        tick();
        chk("wd_err_once", 32'(m_err), 32'h0);
        chk("wd_resume", 32'(s_cyc), 32'h1);
        chk("wd_ack", 32'(m_ack), 32'h1);
        tick();
        s_err = 1'b1;
        settle();
        chk("both_ack", 32'(m_ack), 32'h1);
        chk("both_err", 32'(m_err), 32'h1);

        // reset during a burst, then master0 has priority again
        do_reset();
        m_cyc = 3'b011;
        m_stb = 3'b011;
        tick();
        s_ack = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("mr_cyc_in", 32'(s_cyc), 32'h0);
        chk("mr_ack_in", 32'(m_ack), 32'h0);
        tick();
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_cyc", 32'(s_cyc), 32'h0);
        rst   = 1'b0;
        s_ack = 1'b0;
        tick();
        chk("mr_prio", 32'(grant), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
